servo_pwm_slew: RTL and testbench

Downstream stage of the robot-arm controller. One instance per servo channel.
- Consumes a 32-bit pulse-width command in microseconds.
- Clamps the command to the servo's safe range.
- Moves the actual pulse width toward the command at a bounded rate, once per 20 ms frame, to limit mechanical shock.
- Generates the glitch-free servo PWM that drives a PMOD pin.

---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_us_timebase.sv | 44 ++++
 rtl/servo_pwm_slew.sv | 117 +++++++++++
 tb/tb_servo_pwm_slew.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared widths, default servo limits and the command clamp used by servo_pwm_slew.
package servo_pkg;

  localparam int US_W            = 12;
  localparam int SERVO_MIN_US    = 650;
  localparam int SERVO_MAX_US    = 2600;
  localparam int SERVO_CENTER_US = 1500;
  localparam int SERVO_PERIOD_US = 20000;

  typedef logic [US_W-1:0] us_t;

  // Signed compare so that a negative command from upstream lands on the low limit.
  function automatic us_t clamp_us(input logic signed [31:0] cmd,
                                   input int lo = SERVO_MIN_US,
                                   input int hi = SERVO_MAX_US);
    us_t result;
    if (cmd < lo)
      result = lo[US_W-1:0];
    else if (cmd > hi)
      result = hi[US_W-1:0];
    else
      result = cmd[US_W-1:0];
    return result;
  endfunction

endpackage

// File: rtl/servo_us_timebase.sv
// Microsecond prescaler and PWM frame counter; one instance may serve several servo channels.
module servo_us_timebase #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int PERIOD_US = 20000
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  output logic                         us_tick,
  output logic [$clog2(PERIOD_US)-1:0] frame_cnt,
  output logic                         frame_start
);

  localparam int DIV  = CLK_HZ / 1_000_000;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FC_W = $clog2(PERIOD_US);

  logic [PS_W-1:0] prescaler;

  assign us_tick = (prescaler == PS_W'(DIV - 1));

  // frame_start is registered so it is high during the first cycle with frame_cnt == 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (us_tick)
        prescaler <= '0;
      else
        prescaler <= prescaler + 1'b1;
      if (us_tick) begin
        if (frame_cnt == FC_W'(PERIOD_US - 1)) begin
          frame_cnt   <= '0;
          frame_start <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/servo_pwm_slew.sv
// One servo channel: clamps the command, slews the pulse width once per frame, drives the PWM pin.
// Build option: define SERVO_SLEW_EN to rate-limit width changes to SLEW_US per frame.
module servo_pwm_slew
  import servo_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int PERIOD_US = SERVO_PERIOD_US,
  parameter int MIN_US    = SERVO_MIN_US,
  parameter int MAX_US    = SERVO_MAX_US,
  parameter int CENTER_US = SERVO_CENTER_US,
  parameter int SLEW_US   = 20
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic signed [31:0] cmd_us,
  input  logic               enable,
  output logic               pwm,
  output logic [US_W-1:0]    cur_us,
  output logic               frame_start,
  output logic               at_target,
  output logic               clamped
);

  localparam int FC_W  = $clog2(PERIOD_US);
  localparam int CMP_W = (FC_W > US_W) ? FC_W : US_W;

  if (MAX_US >= 4096 || MAX_US >= PERIOD_US) begin : g_bad_range
    $error("servo_pwm_slew: MAX_US must be below 4096 and below PERIOD_US");
  end
  if (MIN_US > CENTER_US || CENTER_US > MAX_US || SLEW_US < 1 || CLK_HZ < 1_000_000) begin : g_bad_cfg
    $error("servo_pwm_slew: inconsistent MIN/CENTER/MAX, SLEW_US or CLK_HZ");
  end

  logic [1:0]      rst_sync;
  logic            rst_n_int;
  logic            us_tick;
  logic [FC_W-1:0] frame_cnt;
  logic            wrap;
  logic            update;
  logic            upd_d;
  logic            active;
  logic            out_of_range;
  us_t             tgt_next;
  us_t             cur_next;
  us_t             target;

  // Reset asserts immediately but releases two clocks later, in step with CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  servo_us_timebase #(
    .CLK_HZ   (CLK_HZ),
    .PERIOD_US(PERIOD_US)
  ) u_timebase (
    .CLK        (CLK),
    .RST_N      (rst_n_int),
    .us_tick    (us_tick),
    .frame_cnt  (frame_cnt),
    .frame_start(frame_start)
  );

  assign wrap         = us_tick && (frame_cnt == FC_W'(PERIOD_US - 1));
  assign update       = wrap && enable;
  assign tgt_next     = clamp_us(cmd_us, MIN_US, MAX_US);
  assign out_of_range = (cmd_us < MIN_US) || (cmd_us > MAX_US);

`ifdef SERVO_SLEW_EN
  localparam logic signed [US_W:0] SLEW_S = (US_W + 1)'(SLEW_US);
  logic signed [US_W:0] diff;
  assign diff = $signed({1'b0, tgt_next}) - $signed({1'b0, cur_us});
`endif

  always_comb begin
    cur_next = tgt_next;
`ifdef SERVO_SLEW_EN
    if (diff > SLEW_S)
      cur_next = cur_us + US_W'(SLEW_US);
    else if (diff < -SLEW_S)
      cur_next = cur_us - US_W'(SLEW_US);
`endif
  end

  // Width only moves on the frame wrap, so a pulse in flight is never cut short or stretched.
  // active gates pulses until a full frame has started with enable high.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cur_us    <= US_W'(CENTER_US);
      target    <= US_W'(CENTER_US);
      clamped   <= 1'b0;
      at_target <= 1'b0;
      upd_d     <= 1'b0;
      active    <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      upd_d <= update;
      if (update) begin
        target  <= tgt_next;
        clamped <= out_of_range;
        cur_us  <= cur_next;
      end
      if (upd_d)
        at_target <= (cur_us == target);
      if (!enable)
        active <= 1'b0;
      else if (wrap)
        active <= 1'b1;
      pwm <= enable && active && (CMP_W'(frame_cnt) < CMP_W'(cur_us));
    end
  end

endmodule

// File: tb/tb_servo_pwm_slew.sv
// Randomised self-checking bench for servo_pwm_slew, scaled to short frames; honours SERVO_SLEW_EN.
module tb_servo_pwm_slew;

  localparam int CLK_HZ    = 2_000_000;
  localparam int PERIOD_US = 300;
  localparam int MIN_US    = 65;
  localparam int MAX_US    = 260;
  localparam int CENTER_US = 150;
  localparam int SLEW_US   = 20;
  localparam int DIV       = CLK_HZ / 1_000_000;
  localparam int FRAME_CLK = PERIOD_US * DIV;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic signed [31:0] cmd_us = 32'sd0;
  logic               enable = 1'b0;
  logic               pwm;
  logic [11:0]        cur_us;
  logic               frame_start;
  logic               at_target;
  logic               clamped;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: the width, target and flags the servo should hold in the current frame.
  int m_cur;
  int m_target;
  int m_at;
  int m_clamped;
  int m_live;

  servo_pwm_slew #(
    .CLK_HZ   (CLK_HZ),
    .PERIOD_US(PERIOD_US),
    .MIN_US   (MIN_US),
    .MAX_US   (MAX_US),
    .CENTER_US(CENTER_US),
    .SLEW_US  (SLEW_US)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cmd_us     (cmd_us),
    .enable     (enable),
    .pwm        (pwm),
    .cur_us     (cur_us),
    .frame_start(frame_start),
    .at_target  (at_target),
    .clamped    (clamped)
  );

  always #5 CLK = ~CLK;

  initial begin
    #(900_000);
    $display("[TB] FAIL watchdog: observed timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [31:0] cmd, input logic en);
    cmd_us = cmd;
    enable = en;
  endtask

  function automatic int clampModel(input int c);
    if (c < MIN_US) return MIN_US;
    if (c > MAX_US) return MAX_US;
    return c;
  endfunction

  // What the frame boundary should do, given the inputs held at the wrap edge.
  task automatic modelBoundary();
    int t;
    int d;
    m_live = int'(enable);
    if (enable) begin
      t         = clampModel(int'(cmd_us));
      m_clamped = (int'(cmd_us) < MIN_US || int'(cmd_us) > MAX_US) ? 1 : 0;
      d         = t - m_cur;
`ifdef SERVO_SLEW_EN
      if (d > SLEW_US)
        m_cur = m_cur + SLEW_US;
      else if (d < -SLEW_US)
        m_cur = m_cur - SLEW_US;
      else
        m_cur = t;
`else
      m_cur = t;
`endif
      m_target = t;
      m_at     = (m_cur == m_target) ? 1 : 0;
    end
  endtask

  task automatic checkBoundary();
    checkOutput("cur_us_at_frame", int'(cur_us), m_cur);
    checkOutput("clamped_at_frame", int'(clamped), m_clamped);
  endtask

  // Holds reset, checks reset values, releases it and waits for the first frame boundary.
  task automatic doReset();
    int n;
    int stray;
    bit found;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_pwm", int'(pwm), 0);
    checkOutput("reset_cur_us", int'(cur_us), CENTER_US);
    checkOutput("reset_frame_start", int'(frame_start), 0);
    checkOutput("reset_at_target", int'(at_target), 0);
    checkOutput("reset_clamped", int'(clamped), 0);
    m_cur = CENTER_US; m_target = CENTER_US; m_at = 0; m_clamped = 0; m_live = 0;
    RST_N = 1'b1;
    n = 0; stray = 0; found = 1'b0;
    while (!found && n < 2 * FRAME_CLK + 8) begin
      @(negedge CLK);
      n++;
      if (frame_start) found = 1'b1;
      else if (pwm) stray++;
    end
    checkOutput("release_to_first_frame", n, FRAME_CLK + 2);
    checkOutput("pwm_before_first_frame", stray, 0);
    modelBoundary();
    checkBoundary();
  endtask

  // Runs one frame from its frame_start cycle to the next, changing inputs at the given cycles.
  task automatic runFrame(input logic signed [31:0] next_cmd, input int cmd_at,
                          input int off_at, input int on_at);
    int highs = 0, exp_highs = 0, bad = 0, extra_fs = 0, cur_bad = 0;
    int live;
    int exp_pwm;
    live = m_live;
    for (int c = 0; c <= FRAME_CLK; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        live = live & int'(enable);
      end
      if (c < FRAME_CLK) begin
        exp_pwm = (c > 0 && live != 0 && c <= m_cur * DIV) ? 1 : 0;
        if (int'(pwm) != exp_pwm) bad++;
        highs     += int'(pwm);
        exp_highs += exp_pwm;
        if (int'(cur_us) != m_cur) cur_bad++;
        if (c > 0 && frame_start) extra_fs++;
        if (c == 1) checkOutput("at_target", int'(at_target), m_at);
        if (c == cmd_at) cmd_us = next_cmd;
        if (c == off_at) enable = 1'b0;
        if (c == on_at) enable = 1'b1;
      end
    end
    checkOutput("frame_start_period", int'(frame_start), 1);
    checkOutput("pwm_high_cycles", highs, exp_highs);
    checkOutput("pwm_cycle_errors", bad, 0);
    checkOutput("cur_us_mid_frame", cur_bad, 0);
    checkOutput("frame_start_extra", extra_fs, 0);
    modelBoundary();
    checkBoundary();
  endtask

  function automatic int randomCmd();
    int r;
    case ($urandom_range(0, 3))
      0: r = -int'($urandom_range(1, 5000));
      1: r = MAX_US + int'($urandom_range(1, 100000));
      2: r = MIN_US + int'($urandom_range(0, MAX_US - MIN_US));
      default: begin
        case ($urandom_range(0, 3))
          0: r = MIN_US - 1;
          1: r = MIN_US;
          2: r = MAX_US;
          default: r = MAX_US + 1;
        endcase
      end
    endcase
    return r;
  endfunction

  initial begin
    int off_at;
    int on_at;
    int guard;

    applyStimulus(CENTER_US, 1'b1);
    doReset();
    repeat (2) runFrame(CENTER_US, 0, -1, -1);

    runFrame(200, 10, -1, -1);
    repeat (3) runFrame(200, 0, -1, -1);

    repeat (8) runFrame(-100, 0, -1, -1);
    repeat (11) runFrame(9000, 0, -1, -1);

    repeat (7) runFrame(CENTER_US, 0, -1, -1);
    runFrame(260, 2 * 100, -1, -1);
    runFrame(260, 0, -1, -1);

    runFrame(260, 0, 40, -1);
    runFrame(260, 0, -1, 100);
    runFrame(260, 0, -1, -1);

    for (int i = 0; i < 12; i++) begin
      on_at  = enable ? -1 : int'($urandom_range(1, FRAME_CLK / 2));
      off_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(FRAME_CLK / 2, FRAME_CLK - 1)) : -1;
      runFrame(randomCmd(), int'($urandom_range(0, FRAME_CLK - 1)), off_at, on_at);
    end

    applyStimulus(9000, 1'b1);
    guard = 0;
    while (!(m_cur == MAX_US && m_live != 0) && guard < 16) begin
      runFrame(9000, 0, -1, -1);
      guard++;
    end
    repeat (200) @(negedge CLK);
    checkOutput("pwm_before_reset", int'(pwm), 1);
    applyStimulus(CENTER_US, 1'b1);
    RST_N = 1'b0;
    #1;
    checkOutput("pwm_async_reset", int'(pwm), 0);
    doReset();
    runFrame(200, 0, -1, -1);
    repeat (3) runFrame(200, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
